// File: rtl/hs_ifr_evt_gen.sv
// Paced event generator: turns evt_i requests into edge- or level-signalled events
// with a saturating pending count. Define HS_IFR_EVT_GEN_OVF_EN for the sticky overflow flag.
typedef enum logic {BOOL_FALSE, BOOL_TRUE} bool_e;
typedef enum logic [1:0] {EDGE_POSEDGE, EDGE_NEGEDGE, EDGE_BOTH} edge_e;
typedef enum logic [1:0] {LEVEL_HIGH, LEVEL_LOW, LEVEL_BOTH} level_e;

module hs_ifr_evt_gen #(
   parameter bool_e  IS_LEVEL = BOOL_FALSE,
   parameter edge_e  EDGE     = EDGE_POSEDGE,
   parameter level_e LEVEL    = LEVEL_HIGH,
   parameter int     PULSE_W  = 1,
   parameter int     GAP_W    = 2,
   parameter int     CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             evt_i,
   input  logic             ack_i,
   input  logic             ovf_clr_i,
   output logic             evt_o,
   output logic [CNT_W-1:0] pend_o,
   output logic             busy_o,
   output logic             ovf_o
);

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_e;

   localparam bit               LVL_MODE = (IS_LEVEL == BOOL_TRUE);
   localparam bit               TOGGLE   = !LVL_MODE && (EDGE == EDGE_BOTH);
   localparam logic             IDLE_LVL = LVL_MODE ? (LEVEL == LEVEL_LOW) : (EDGE == EDGE_NEGEDGE);
   localparam logic [3:0]       PULSE_LD = 4'(PULSE_W - 1);
   localparam logic [3:0]       GAP_LD   = 4'(GAP_W - 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

   if (LEVEL == LEVEL_BOTH) begin : g_bad_level
      $error("hs_ifr_evt_gen: LEVEL_BOTH is not a valid active level");
   end
   if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse
      $error("hs_ifr_evt_gen: PULSE_W must be 1..15");
   end
   if (GAP_W < 0 || GAP_W > 15) begin : g_bad_gap
      $error("hs_ifr_evt_gen: GAP_W must be 0..15");
   end

   state_e           state;
   logic [3:0]       cnt;
   logic [CNT_W-1:0] pend;
   logic             evt_q;
   logic             busy_q;
   logic             act_done;
   logic             dec;
   logic             full;
   logic             drop;
   logic             start;

   assign act_done = LVL_MODE ? ack_i : (cnt == 4'd0);
   assign dec      = (state == ACTIVE) && act_done;
   assign full     = (pend == PEND_MAX);
   assign drop     = evt_i && full && !dec;
   assign start    = (pend != '0) || evt_i;

   // EDGE_BOTH toggles on entry and holds on exit; other styles drive fixed levels
   function automatic logic enter_lvl(input logic cur);
      return TOGGLE ? ~cur : ~IDLE_LVL;
   endfunction

   function automatic logic leave_lvl(input logic cur);
      return TOGGLE ? cur : IDLE_LVL;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         pend   <= '0;
         evt_q  <= IDLE_LVL;
         busy_q <= 1'b0;
      end else begin
         if (evt_i && !dec && !full)
            pend <= pend + PEND_ONE;
         else if (dec && !evt_i)
            pend <= pend - PEND_ONE;

         case (state)
            IDLE: begin
               if (start) begin
                  state  <= ACTIVE;
                  cnt    <= PULSE_LD;
                  evt_q  <= enter_lvl(evt_q);
                  busy_q <= 1'b1;
               end
            end
            ACTIVE: begin
               if (act_done) begin
                  evt_q <= leave_lvl(evt_q);
                  if (GAP_W == 0) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= GAP;
                     cnt   <= GAP_LD;
                  end
               end else if (!LVL_MODE) begin
                  cnt <= cnt - 4'd1;
               end
            end
            GAP: begin
               // queued work chains straight into the next pulse once the gap is served
               if (cnt == 4'd0) begin
                  if (start) begin
                     state <= ACTIVE;
                     cnt   <= PULSE_LD;
                     evt_q <= enter_lvl(evt_q);
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign evt_o  = evt_q;
   assign pend_o = pend;
   assign busy_o = busy_q;

`ifdef HS_IFR_EVT_GEN_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (drop)
         ovf_q <= 1'b1;
      else if (ovf_clr_i)
         ovf_q <= 1'b0;
   end

   assign ovf_o = ovf_q;
`else
   logic unused_ovf;

   assign unused_ovf = ovf_clr_i | drop;
   assign ovf_o      = 1'b0;
`endif

endmodule

// File: tb/tb_hs_ifr_evt_gen.sv
// Scoreboard bench for hs_ifr_evt_gen: five differently configured instances share
// one clock; expectations are queued with each stimulus step and checked after the edge.
module tb_hs_ifr_evt_gen;

`ifdef HS_IFR_EVT_GEN_OVF_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] evt;
   logic [4:0] ack;
   logic [4:0] clr;
   logic [4:0] eo;
   logic [4:0] busy;
   logic [4:0] ovf;
   logic [3:0] pend0, pend1, pend2, pend3;
   logic [1:0] pend4;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      string tag;
      int    inst;
      logic  eo;
      logic  busy;
      int    pend;
      logic  ovf;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   hs_ifr_evt_gen u0 (
      .clk(clk), .rst(rst), .evt_i(evt[0]), .ack_i(ack[0]), .ovf_clr_i(clr[0]),
      .evt_o(eo[0]), .pend_o(pend0), .busy_o(busy[0]), .ovf_o(ovf[0]));

   hs_ifr_evt_gen #(.EDGE(EDGE_NEGEDGE), .PULSE_W(3)) u1 (
      .clk(clk), .rst(rst), .evt_i(evt[1]), .ack_i(ack[1]), .ovf_clr_i(clr[1]),
      .evt_o(eo[1]), .pend_o(pend1), .busy_o(busy[1]), .ovf_o(ovf[1]));

   hs_ifr_evt_gen #(.EDGE(EDGE_BOTH)) u2 (
      .clk(clk), .rst(rst), .evt_i(evt[2]), .ack_i(ack[2]), .ovf_clr_i(clr[2]),
      .evt_o(eo[2]), .pend_o(pend2), .busy_o(busy[2]), .ovf_o(ovf[2]));

   hs_ifr_evt_gen #(.IS_LEVEL(BOOL_TRUE), .LEVEL(LEVEL_LOW)) u3 (
      .clk(clk), .rst(rst), .evt_i(evt[3]), .ack_i(ack[3]), .ovf_clr_i(clr[3]),
      .evt_o(eo[3]), .pend_o(pend3), .busy_o(busy[3]), .ovf_o(ovf[3]));

   hs_ifr_evt_gen #(.IS_LEVEL(BOOL_TRUE), .CNT_W(2)) u4 (
      .clk(clk), .rst(rst), .evt_i(evt[4]), .ack_i(ack[4]), .ovf_clr_i(clr[4]),
      .evt_o(eo[4]), .pend_o(pend4), .busy_o(busy[4]), .ovf_o(ovf[4]));

   function automatic logic [31:0] get_pend(input int inst);
      case (inst)
         0:       return {28'd0, pend0};
         1:       return {28'd0, pend1};
         2:       return {28'd0, pend2};
         3:       return {28'd0, pend3};
         default: return {30'd0, pend4};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic push(input string tag, input int inst, input logic e, input logic b,
                       input int p, input logic o);
      exp_t x;
      x.tag  = tag;
      x.inst = inst;
      x.eo   = e;
      x.busy = b;
      x.pend = p;
      x.ovf  = o;
      sbq.push_back(x);
   endtask

   task automatic step();
      exp_t x;
      @(posedge clk);
      #1;
      while (sbq.size() > 0) begin
         x = sbq.pop_front();
         check({x.tag, "_evt_o"},  {31'd0, eo[x.inst]},   {31'd0, x.eo});
         check({x.tag, "_busy_o"}, {31'd0, busy[x.inst]}, {31'd0, x.busy});
         check({x.tag, "_pend_o"}, get_pend(x.inst),      x.pend);
         check({x.tag, "_ovf_o"},  {31'd0, ovf[x.inst]},  {31'd0, x.ovf});
      end
      evt = '0;
      ack = '0;
      clr = '0;
   endtask

   logic b_eo[16]   = '{0,0,0,1,1,0,0,0,1,1,0,0,0,1,1,1};
   int   b_pend[16] = '{1,2,3,2,2,2,2,2,1,1,1,1,1,0,0,0};
   logic c_eo[13]   = '{1,1,1,0,0,0,1,1,1,0,0,0,0};
   int   c_pend[13] = '{1,1,2,3,2,2,2,1,1,1,0,0,0};
   logic rst_eo[5]  = '{0,1,0,1,0};

   initial begin
      rst = 1'b1;
      evt = '0;
      ack = '0;
      clr = '0;
      step();
      for (int i = 0; i < 5; i++) push("reset", i, rst_eo[i], 1'b0, 0, 1'b0);
      step();
      rst = 1'b0;

      // single default-config event
      evt[0] = 1'b1;
      push("pos_act", 0, 1'b1, 1'b1, 1, 1'b0);
      step();
      push("pos_gap1", 0, 1'b0, 1'b1, 0, 1'b0);
      step();
      push("pos_gap2", 0, 1'b0, 1'b1, 0, 1'b0);
      step();
      push("pos_idle", 0, 1'b0, 1'b0, 0, 1'b0);
      step();

      // negedge, 3-cycle pulses, three back-to-back requests
      for (int i = 0; i < 16; i++) begin
         evt[1] = (i < 3);
         push($sformatf("neg_%0d", i), 1, b_eo[i], (i != 15), b_pend[i], 1'b0);
         step();
      end

      // toggle style, four requests
      for (int i = 0; i < 13; i++) begin
         evt[2] = (i < 4);
         push($sformatf("both_%0d", i), 2, c_eo[i], (i != 12), c_pend[i], 1'b0);
         step();
      end

      // level-low with late acknowledge; an early ack while idle does nothing
      ack[3] = 1'b1;
      push("lvl_idle_ack", 3, 1'b1, 1'b0, 0, 1'b0);
      step();
      for (int i = 1; i <= 10; i++) begin
         evt[3] = (i == 1);
         ack[3] = (i == 8);
         push($sformatf("lvl_%0d", i), 3, (i > 7), (i <= 9), (i <= 7) ? 1 : 0, 1'b0);
         step();
      end

      // saturation and overflow on the 2-bit counter, never acknowledged
      for (int i = 1; i <= 5; i++) begin
         evt[4] = 1'b1;
         push($sformatf("sat_%0d", i), 4, 1'b1, 1'b1, (i < 3) ? i : 3, (i >= 4) ? OVF_ON : 1'b0);
         step();
      end
      clr[4] = 1'b1;
      push("ovf_clr", 4, 1'b1, 1'b1, 3, 1'b0);
      step();
      evt[4] = 1'b1;
      clr[4] = 1'b1;
      push("ovf_set_clr", 4, 1'b1, 1'b1, 3, OVF_ON);
      step();
      clr[4] = 1'b1;
      push("ovf_clr2", 4, 1'b1, 1'b1, 3, 1'b0);
      step();
      push("ovf_hold", 4, 1'b1, 1'b1, 3, 1'b0);
      step();

      // reset in the middle of an active level event with two pending
      evt[3] = 1'b1;
      push("mid_a1", 3, 1'b0, 1'b1, 1, 1'b0);
      step();
      evt[3] = 1'b1;
      push("mid_a2", 3, 1'b0, 1'b1, 2, 1'b0);
      step();
      rst    = 1'b1;
      evt[3] = 1'b1;
      ack[3] = 1'b1;
      evt[4] = 1'b1;
      push("mid_rst3", 3, 1'b1, 1'b0, 0, 1'b0);
      push("mid_rst4", 4, 1'b0, 1'b0, 0, 1'b0);
      step();
      rst = 1'b0;
      push("post_rst3", 3, 1'b1, 1'b0, 0, 1'b0);
      push("post_rst4", 4, 1'b0, 1'b0, 0, 1'b0);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hs_ifr_evt_gen.md
HS_IFR_EVT_GEN -- requirements
Module: hs_ifr_evt_gen

Interface
REQ-001 SHALL have parameter IS_LEVEL, bool_e, default BOOL_FALSE: BOOL_TRUE = level-signalled output, BOOL_FALSE = edge-signalled output.
REQ-002 SHALL have parameter EDGE, edge_e, default EDGE_POSEDGE: edge-mode signalling style.
REQ-003 SHALL have parameter LEVEL, level_e, default LEVEL_HIGH: level-mode active level. LEVEL_BOTH SHALL raise an elaboration $error.
REQ-004 SHALL have parameter PULSE_W, int, default 1 (range 1..15): edge-mode active cycles per event.
REQ-005 SHALL have parameter GAP_W, int, default 2 (range 0..15): minimum idle cycles between events.
REQ-006 SHALL have parameter CNT_W, int, default 4: pending-counter width.
REQ-007 clk  input  1  clock; all logic on posedge.
REQ-008 rst  input  1  reset; one clock, synchronous, active-high.
REQ-009 evt_i  input  1  event request; each high cycle is one event.
REQ-010 ack_i  input  1  level-mode acknowledge; ignored in edge mode.
REQ-011 ovf_clr_i  input  1  clears sticky overflow.
REQ-012 evt_o  output  1  generated event signal, registered.
REQ-013 pend_o  output  CNT_W  events queued, not yet signalled.
REQ-014 busy_o  output  1  high when FSM not in IDLE.
REQ-015 ovf_o  output  1  sticky overflow flag.

Function
REQ-016 FSM states SHALL be IDLE, ACTIVE, GAP.
REQ-017 IDLE->ACTIVE SHALL occur when pend_o != 0 or evt_i = 1; evt_o first active in the cycle after evt_i is sampled (latency 1).
REQ-018 Edge mode: ACTIVE SHALL last exactly PULSE_W cycles, then GAP.
REQ-019 Level mode: ACTIVE SHALL hold until ack_i sampled high, then GAP; ack_i outside ACTIVE SHALL be ignored.
REQ-020 GAP SHALL last GAP_W cycles, then IDLE; GAP_W = 0 SHALL go ACTIVE->IDLE directly.
REQ-021 EDGE_POSEDGE: idle 0, active 1. EDGE_NEGEDGE: idle 1, active 0. EDGE_BOTH: evt_o toggles once on ACTIVE entry and holds; PULSE_W only sets ACTIVE duration.
REQ-022 Level mode: evt_o = active level in ACTIVE, inverse otherwise.
REQ-023 Pending counter SHALL increment on evt_i and decrement on ACTIVE exit; both in the same cycle SHALL leave it unchanged.
REQ-024 The event that starts ACTIVE from IDLE with pend_o = 0 SHALL be counted, so pend_o = 1 during its ACTIVE phase.
REQ-025 Counter SHALL saturate at 2^CNT_W-1; an evt_i at saturation without simultaneous decrement SHALL be dropped.
REQ-026 busy_o SHALL be registered and equal (state != IDLE).

Reset
REQ-027 rst SHALL force state IDLE, pend_o 0, ovf_o 0, busy_o 0, and GAP/pulse counters 0.
REQ-028 evt_o reset value SHALL be: POSEDGE 0, NEGEDGE 1, BOTH 0, level mode inactive level.
REQ-029 rst asserted mid-ACTIVE or mid-GAP SHALL abort the event without decrement; evt_i and ack_i in a reset cycle SHALL be ignored.

Configuration
REQ-030 Macro HS_IFR_EVT_GEN_OVF_EN defined: ovf_o SHALL set on a dropped event (REQ-025) and clear on ovf_clr_i; set and clear in the same cycle SHALL leave it set.
REQ-031 Macro HS_IFR_EVT_GEN_OVF_EN undefined: ovf_o SHALL be tied 0, ovf_clr_i unused; all other behaviour identical.

Verification
REQ-032 Defaults, one evt_i pulse at cycle 10 -> evt_o 1 in cycle 11 only, busy_o high cycles 11..13, pend_o 1 in cycle 11 then 0.
REQ-033 EDGE_NEGEDGE, PULSE_W=3, evt_i high 3 consecutive cycles -> three low pulses of 3 cycles each, separated by 2 high cycles; pend_o peaks at 3, ends 0.
REQ-034 EDGE_BOTH, 4 events -> evt_o toggles 4 times, final value 0.
REQ-035 IS_LEVEL=BOOL_TRUE, LEVEL_LOW, evt_i once, ack_i at cycle +7 -> evt_o 0 for cycles +1..+7, 1 after; pend_o back to 0.
REQ-036 CNT_W=2, OVF_EN defined, level mode no ack, 5 evt_i cycles -> pend_o saturates at 3, ovf_o 1; ovf_clr_i -> ovf_o 0; OVF_EN undefined -> ovf_o stays 0.
REQ-037 rst mid-ACTIVE with pend_o = 2 -> next cycle pend_o 0, evt_o idle value, busy_o 0.
